// File: rtl/axil_bram_pkg.sv
// Shared types and constants for the AXI4-Lite to native BRAM bridge.
package axil_bram_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WR_ACCESS = 3'd1,
    WR_RESP   = 3'd2,
    RD_ACCESS = 3'd3,
    RD_WAIT   = 3'd4,
    RD_RESP   = 3'd5
  } axil_state_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Cycles from a read-enable cycle until bram_dout is valid.
  localparam int BRAM_RD_LAT = 1;

endpackage

// File: rtl/axil_bram_bridge.sv
// AXI4-Lite slave serialising single-beat reads/writes onto a single-port BRAM.
// Define AXIL_BRAM_WSTRB_EN to forward wstrb as byte enables; otherwise every write is full-word.
module axil_bram_bridge
  import axil_bram_pkg::*;
#(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 12,
  parameter int C_BRAM_DEPTH       = 1024
) (
  input  logic                              s00_axi_aclk,
  input  logic                              s00_axi_aresetn,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     s00_axi_awaddr,
  input  logic [2:0]                        s00_axi_awprot,
  input  logic                              s00_axi_awvalid,
  output logic                              s00_axi_awready,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]     s00_axi_wdata,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   s00_axi_wstrb,
  input  logic                              s00_axi_wvalid,
  output logic                              s00_axi_wready,
  output logic [1:0]                        s00_axi_bresp,
  output logic                              s00_axi_bvalid,
  input  logic                              s00_axi_bready,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     s00_axi_araddr,
  input  logic [2:0]                        s00_axi_arprot,
  input  logic                              s00_axi_arvalid,
  output logic                              s00_axi_arready,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     s00_axi_rdata,
  output logic [1:0]                        s00_axi_rresp,
  output logic                              s00_axi_rvalid,
  input  logic                              s00_axi_rready,
  output logic                              bram_en,
  output logic [C_S_AXI_DATA_WIDTH/8-1:0]   bram_we,
  output logic [$clog2(C_BRAM_DEPTH)-1:0]   bram_addr,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     bram_din,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]     bram_dout
);

  localparam int WA   = C_S_AXI_ADDR_WIDTH - 2;
  localparam int BA_W = $clog2(C_BRAM_DEPTH);
  localparam int DW   = C_S_AXI_DATA_WIDTH;
  localparam int SW   = C_S_AXI_DATA_WIDTH / 8;
  localparam logic [WA:0] DEPTH_W = (WA+1)'(C_BRAM_DEPTH);

  function automatic logic in_range(input logic [WA-1:0] word);
    in_range = ({1'b0, word} < DEPTH_W);
  endfunction

  axil_state_e     state_q, state_d;
  logic            alive_q;
  logic            aw_held_q, aw_held_d;
  logic            w_held_q, w_held_d;
  logic            last_wr_q, last_wr_d;
  logic [1:0]      bresp_q, bresp_d;
  logic [1:0]      rresp_q, rresp_d;
  logic [DW-1:0]   rdata_q, rdata_d;
  logic [WA-1:0]   aw_word_q, aw_word_d;
  logic [WA-1:0]   ar_word_q, ar_word_d;
  logic [DW-1:0]   wdata_q, wdata_d;
  logic            ar_ok, rd_take;
`ifdef AXIL_BRAM_WSTRB_EN
  logic [SW-1:0]   wstrb_q, wstrb_d;
`else
  logic            unused_wstrb;
  assign unused_wstrb = ^s00_axi_wstrb;
`endif

  // Protection bits and sub-word address bits carry no meaning for this memory.
  logic unused_ok;
  assign unused_ok = ^{s00_axi_awprot, s00_axi_arprot,
                       s00_axi_awaddr[1:0], s00_axi_araddr[1:0]};

  assign s00_axi_bvalid = (state_q == WR_RESP);
  assign s00_axi_rvalid = (state_q == RD_RESP);
  assign s00_axi_bresp  = bresp_q;
  assign s00_axi_rresp  = rresp_q;
  assign s00_axi_rdata  = rdata_q;

  always_comb begin
    state_d   = state_q;
    aw_held_d = aw_held_q;
    w_held_d  = w_held_q;
    last_wr_d = last_wr_q;
    bresp_d   = bresp_q;
    rresp_d   = rresp_q;
    rdata_d   = rdata_q;
    aw_word_d = aw_word_q;
    ar_word_d = ar_word_q;
    wdata_d   = wdata_q;
`ifdef AXIL_BRAM_WSTRB_EN
    wstrb_d   = wstrb_q;
`endif
    ar_ok           = 1'b0;
    rd_take         = 1'b0;
    s00_axi_awready = 1'b0;
    s00_axi_wready  = 1'b0;
    s00_axi_arready = 1'b0;
    bram_en   = 1'b0;
    bram_we   = '0;
    bram_addr = '0;
    bram_din  = '0;

    case (state_q)
      IDLE: begin
        if (alive_q) begin
          // A read is only taken with nothing held; it beats a competing write
          // only when the previous transaction served was a write.
          ar_ok = !aw_held_q && !w_held_q &&
                  (last_wr_q || !(s00_axi_awvalid || s00_axi_wvalid));
          rd_take         = ar_ok && s00_axi_arvalid;
          s00_axi_arready = ar_ok;
          s00_axi_awready = !aw_held_q && !rd_take;
          s00_axi_wready  = !w_held_q && !rd_take;
          if (s00_axi_awready && s00_axi_awvalid) begin
            aw_held_d = 1'b1;
            aw_word_d = s00_axi_awaddr[C_S_AXI_ADDR_WIDTH-1:2];
          end
          if (s00_axi_wready && s00_axi_wvalid) begin
            w_held_d = 1'b1;
            wdata_d  = s00_axi_wdata;
`ifdef AXIL_BRAM_WSTRB_EN
            wstrb_d  = s00_axi_wstrb;
`endif
          end
          if (rd_take) begin
            ar_word_d = s00_axi_araddr[C_S_AXI_ADDR_WIDTH-1:2];
            last_wr_d = 1'b0;
            state_d   = RD_ACCESS;
          end else if (aw_held_d && w_held_d) begin
            last_wr_d = 1'b1;
            state_d   = WR_ACCESS;
          end
        end
      end

      WR_ACCESS: begin
        if (in_range(aw_word_q)) begin
          bram_en   = 1'b1;
`ifdef AXIL_BRAM_WSTRB_EN
          bram_we   = wstrb_q;
`else
          bram_we   = '1;
`endif
          bram_addr = aw_word_q[BA_W-1:0];
          bram_din  = wdata_q;
          bresp_d   = RESP_OKAY;
        end else begin
          bresp_d   = RESP_SLVERR;
        end
        state_d = WR_RESP;
      end

      WR_RESP: begin
        if (s00_axi_bready) begin
          aw_held_d = 1'b0;
          w_held_d  = 1'b0;
          state_d   = IDLE;
        end
      end

      RD_ACCESS: begin
        if (in_range(ar_word_q)) begin
          bram_en   = 1'b1;
          bram_addr = ar_word_q[BA_W-1:0];
          rresp_d   = RESP_OKAY;
          state_d   = RD_WAIT;
        end else begin
          rdata_d   = '0;
          rresp_d   = RESP_SLVERR;
          state_d   = RD_RESP;
        end
      end

      RD_WAIT: begin
        rdata_d = bram_dout;
        state_d = RD_RESP;
      end

      RD_RESP: begin
        if (s00_axi_rready) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  // alive_q keeps every ready low while reset is asserted and for the first cycle after.
  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      state_q   <= IDLE;
      alive_q   <= 1'b0;
      aw_held_q <= 1'b0;
      w_held_q  <= 1'b0;
      last_wr_q <= 1'b0;
      bresp_q   <= RESP_OKAY;
      rresp_q   <= RESP_OKAY;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      alive_q   <= 1'b1;
      aw_held_q <= aw_held_d;
      w_held_q  <= w_held_d;
      last_wr_q <= last_wr_d;
      bresp_q   <= bresp_d;
      rresp_q   <= rresp_d;
      rdata_q   <= rdata_d;
    end
  end

  always_ff @(posedge s00_axi_aclk) begin
    aw_word_q <= aw_word_d;
    ar_word_q <= ar_word_d;
    wdata_q   <= wdata_d;
`ifdef AXIL_BRAM_WSTRB_EN
    wstrb_q   <= wstrb_d;
`endif
  end

endmodule
